// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, instruction
// classes, control-field codes and the opcode/funct values it recognises.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MADDR  = 4'd2,
        S_MRD    = 4'd3,
        S_MWB    = 4'd4,
        S_MWR    = 4'd5,
        S_EXE    = 4'd6,
        S_AWB    = 4'd7,
        S_BR     = 4'd8,
        S_JMP    = 4'd9,
        S_MDU    = 4'd10
    } state_e;

    typedef enum logic [2:0] {
        CL_ILL   = 3'd0,
        CL_LOAD  = 3'd1,
        CL_STORE = 3'd2,
        CL_ALU   = 3'd3,
        CL_BR    = 3'd4,
        CL_JMP   = 3'd5,
        CL_MDU   = 3'd6
    } icls_e;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_OR   = 3'd2;
    localparam logic [2:0] ALU_SLT  = 3'd3;
    localparam logic [2:0] ALU_ADDV = 3'd4;
    localparam logic [2:0] ALU_AND  = 3'd5;

    localparam logic [1:0] GPR_RT  = 2'b00;
    localparam logic [1:0] GPR_RD  = 2'b01;
    localparam logic [1:0] GPR_RA  = 2'b10;
    localparam logic [1:0] GPR_R30 = 2'b11;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_DM  = 2'b01;
    localparam logic [1:0] WD_PC4 = 2'b10;
    localparam logic [1:0] WD_ONE = 2'b11;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    localparam logic [1:0] NPC_PC4 = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;
    localparam logic [1:0] NPC_JR  = 2'b11;

    localparam logic [1:0] BS_WORD = 2'b00;
    localparam logic [1:0] BS_HALF = 2'b01;
    localparam logic [1:0] BS_BYTE = 2'b10;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2a;

    // States that wait on mem_ready and run the timeout counter.
    function automatic logic is_wait_state(input state_e s);
        return (s == S_FETCH) || (s == S_MRD) || (s == S_MWR);
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decode: classifies opcode/funct and produces the
// datapath select fields. MC_CTRL_MDU_EN adds the multiply/divide encodings.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    input  logic       overflow_i,
    output icls_e      cls_o,
    output logic       is_bne_o,
    output logic       link_o,
    output logic [2:0] aluop_o,
    output logic [1:0] extop_o,
    output logic       bsel_o,
    output logic [1:0] gprsel_o,
    output logic [1:0] wdsel_o,
    output logic [1:0] bytesel_o,
    output logic       ldsign_o,
    output logic [1:0] npcop_o
);

    // Opcode/funct table; anything not listed falls through as illegal.
    always_comb begin
        cls_o     = CL_ILL;
        is_bne_o  = 1'b0;
        link_o    = 1'b0;
        aluop_o   = ALU_ADD;
        extop_o   = EXT_ZERO;
        bsel_o    = 1'b0;
        gprsel_o  = GPR_RT;
        wdsel_o   = WD_ALU;
        bytesel_o = BS_WORD;
        ldsign_o  = 1'b0;
        npcop_o   = NPC_PC4;
        case (opcode_i)
            OP_RTYPE: begin
                gprsel_o = GPR_RD;
                case (funct_i)
                    FN_ADDU: begin cls_o = CL_ALU; aluop_o = ALU_ADD; end
                    FN_SUBU: begin cls_o = CL_ALU; aluop_o = ALU_SUB; end
                    FN_AND:  begin cls_o = CL_ALU; aluop_o = ALU_AND; end
                    FN_OR:   begin cls_o = CL_ALU; aluop_o = ALU_OR;  end
                    FN_SLT:  begin cls_o = CL_ALU; aluop_o = ALU_SLT; end
                    FN_JR:   begin cls_o = CL_JMP; npcop_o = NPC_JR;  end
                    FN_JALR: begin
                        cls_o   = CL_JMP;
                        npcop_o = NPC_JR;
                        link_o  = 1'b1;
                        wdsel_o = WD_PC4;
                    end
`ifdef MC_CTRL_MDU_EN
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: cls_o = CL_MDU;
                    FN_MFHI, FN_MFLO:                   cls_o = CL_ALU;
`endif
                    default: cls_o = CL_ILL;
                endcase
            end
            OP_ADDI: begin
                cls_o   = CL_ALU;
                aluop_o = ALU_ADDV;
                extop_o = EXT_SIGN;
                bsel_o  = 1'b1;
                // Overflowing addi leaves rt alone and flags $30 instead.
                gprsel_o = overflow_i ? GPR_R30 : GPR_RT;
                wdsel_o  = overflow_i ? WD_ONE : WD_ALU;
            end
            OP_ADDIU: begin cls_o = CL_ALU; extop_o = EXT_SIGN; bsel_o = 1'b1; end
            OP_ORI:   begin cls_o = CL_ALU; aluop_o = ALU_OR; bsel_o = 1'b1; end
            OP_LUI:   begin cls_o = CL_ALU; extop_o = EXT_LUI; bsel_o = 1'b1; end
            OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: begin
                cls_o     = CL_LOAD;
                extop_o   = EXT_SIGN;
                bsel_o    = 1'b1;
                wdsel_o   = WD_DM;
                bytesel_o = (opcode_i == OP_LW) ? BS_WORD :
                            ((opcode_i == OP_LH) || (opcode_i == OP_LHU)) ? BS_HALF : BS_BYTE;
                ldsign_o  = (opcode_i == OP_LH) || (opcode_i == OP_LB);
            end
            OP_SW, OP_SH, OP_SB: begin
                cls_o     = CL_STORE;
                extop_o   = EXT_SIGN;
                bsel_o    = 1'b1;
                bytesel_o = (opcode_i == OP_SW) ? BS_WORD :
                            (opcode_i == OP_SH) ? BS_HALF : BS_BYTE;
            end
            OP_BEQ, OP_BNE: begin
                cls_o    = CL_BR;
                aluop_o  = ALU_SUB;
                extop_o  = EXT_SIGN;
                npcop_o  = NPC_BR;
                is_bne_o = (opcode_i == OP_BNE);
            end
            OP_J:   begin cls_o = CL_JMP; npcop_o = NPC_J; end
            OP_JAL: begin
                cls_o    = CL_JMP;
                npcop_o  = NPC_J;
                link_o   = 1'b1;
                gprsel_o = GPR_RA;
                wdsel_o  = WD_PC4;
            end
            default: cls_o = CL_ILL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_hs.sv
// Multi-cycle MIPS control FSM with mem_ready handshake and wait-state timeout.
// Define MC_CTRL_MDU_EN to add the MDU state and the mdu_start/mdu_busy ports.
module mc_ctrl_hs
    import mc_pkg::*;
#(
    parameter int ALUOP_W = 4,
    parameter int MEM_TO  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               overflow,
    input  logic               mem_ready,
    output logic [ALUOP_W-1:0] aluop,
    output logic [1:0]         gprsel,
    output logic [1:0]         wdsel,
    output logic [1:0]         extop,
    output logic [1:0]         npcop,
    output logic               bsel,
    output logic               gprwr,
    output logic               pcwr,
    output logic               irwr,
    output logic               imrd,
    output logic               dmrd,
    output logic               dmwr,
    output logic [1:0]         bytesel,
    output logic               ldsign,
    output logic               illegal,
    output logic               bus_err,
    output logic [3:0]         state_o
`ifdef MC_CTRL_MDU_EN
    ,
    input  logic               mdu_busy,
    output logic               mdu_start
`endif
);

    localparam int CNT_W = $clog2(MEM_TO + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MEM_TO - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    icls_e            cls_s;
    logic             is_bne_s;
    logic             link_s;
    logic [2:0]       aluop_s;
    logic [1:0]       npcop_s;
    logic             timeout_s;

    mc_decode u_decode (
        .opcode_i   (opcode),
        .funct_i    (funct),
        .overflow_i (overflow),
        .cls_o      (cls_s),
        .is_bne_o   (is_bne_s),
        .link_o     (link_s),
        .aluop_o    (aluop_s),
        .extop_o    (extop),
        .bsel_o     (bsel),
        .gprsel_o   (gprsel),
        .wdsel_o    (wdsel),
        .bytesel_o  (bytesel),
        .ldsign_o   (ldsign),
        .npcop_o    (npcop_s)
    );

    // mem_ready on the last allowed cycle wins over the timeout.
    assign timeout_s = is_wait_state(state_q) && !mem_ready && (cnt_q == TO_LAST);

    // State register and wait counter; the counter restarts on every transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= {CNT_W{1'b0}};
            case (state_q)
                S_FETCH: begin
                    if (mem_ready)      state_q <= S_DECODE;
                    else if (timeout_s) state_q <= S_FETCH;
                    else                cnt_q   <= cnt_q + CNT_ONE;
                end
                S_DECODE: begin
                    case (cls_s)
                        CL_LOAD, CL_STORE: state_q <= S_MADDR;
                        CL_ALU:            state_q <= S_EXE;
                        CL_BR:             state_q <= S_BR;
                        CL_JMP:            state_q <= S_JMP;
`ifdef MC_CTRL_MDU_EN
                        CL_MDU:            state_q <= S_MDU;
`endif
                        default:           state_q <= S_FETCH;
                    endcase
                end
                S_MADDR: state_q <= (cls_s == CL_STORE) ? S_MWR : S_MRD;
                S_MRD: begin
                    if (mem_ready)      state_q <= S_MWB;
                    else if (timeout_s) state_q <= S_FETCH;
                    else                cnt_q   <= cnt_q + CNT_ONE;
                end
                S_MWR: begin
                    if (mem_ready || timeout_s) state_q <= S_FETCH;
                    else                        cnt_q   <= cnt_q + CNT_ONE;
                end
                S_EXE: state_q <= S_AWB;
`ifdef MC_CTRL_MDU_EN
                S_MDU: state_q <= mdu_busy ? S_MDU : S_FETCH;
`endif
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Write/request strobes decoded from state, held low while rst is asserted.
    always_comb begin
        imrd    = !rst && (state_q == S_FETCH);
        irwr    = !rst && (state_q == S_FETCH) && mem_ready;
        pcwr    = !rst && (((state_q == S_FETCH) && mem_ready) ||
                           ((state_q == S_BR) && (zero ^ is_bne_s)) ||
                           (state_q == S_JMP));
        gprwr   = !rst && ((state_q == S_MWB) || (state_q == S_AWB) ||
                           ((state_q == S_JMP) && link_s));
        dmrd    = !rst && (state_q == S_MRD);
        dmwr    = !rst && (state_q == S_MWR);
        illegal = !rst && (state_q == S_DECODE) && (cls_s == CL_ILL);
        bus_err = !rst && timeout_s;
`ifdef MC_CTRL_MDU_EN
        mdu_start = !rst && (state_q == S_DECODE) && (cls_s == CL_MDU);
`endif
    end

    // Instruction fetch always advances sequentially, whatever the stale IR says.
    assign npcop   = (state_q == S_FETCH) ? NPC_PC4 : npcop_s;
    assign aluop   = {{(ALUOP_W-3){1'b0}}, aluop_s};
    assign state_o = state_q;

endmodule
